systolic_drain_collector: RTL
=============================

Name: systolic_drain_collector

Overview:
- Drains results from the bottom edge of a systolic MAC array. Column j of the array presents its out_c samples skewed by j cycles.
- De-skews the columns into aligned result rows, buffers them in a FIFO, and hands rows downstream on a valid/ready interface.
- Counts delivered rows per tile and flags protocol errors. It sits between the array's bottom-row elements and the result writeback logic.

Parameters:
- data_size, 16, width of one signed result element (matches array element width)
- cols, 4, number of array columns / elements per result row
- fifo_depth, 8, aligned-row FIFO entries (power of 2, >=2)
- cnt_width, 8, width of the tile row counter and tile_rows

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: latch tile_rows, clear row counter and error flags
- tile_rows  in  cnt_width  number of result rows expected for this tile (0 = none)
- col_valid  in  cols  per-column sample valid from array control; bit j = bit 0 delayed j cycles
- col_data  in  cols*data_size  signed column samples, column j at bits [j*data_size +: data_size]
- out_valid  out  1  aligned row available
- out_ready  in  1  downstream accepts row when out_valid & out_ready
- out_row  out  cols*data_size  aligned row, same column packing as col_data
- fifo_count  out  log2(fifo_depth)+1  occupied entries
- tile_done  out  1  one-cycle pulse when the tile_rows-th row is popped
- overflow  out  1  sticky: a row was dropped because the FIFO was full
- skew_err  out  1  sticky: col_valid[cols-1] disagreed with the delayed col_valid[0]

Behaviour:
- Reset (async, reset=0): all delay registers, FIFO pointers, count, row counter and flags cleared. out_valid=0, out_row=0, fifo_count=0, tile_done=0, overflow=0, skew_err=0.
- De-skew: column j data is delayed by cols-1-j register stages, gated by its col_valid bit. Column cols-1 uses zero stages. col_valid[0] is delayed cols-1 stages to form row_push.
- Row timing: a row whose column j sample is presented at edge t0+j is written to the FIFO at edge t0+cols-1.
  - If the FIFO was empty, out_valid rises in the following cycle, holding that row.
- Skew check: at every edge where delayed col_valid[0] != col_valid[cols-1], set skew_err. The row is still pushed per row_push.
- FIFO: synchronous, first-word-fall-through.
  - out_row is the head entry whenever out_valid=1.
  - out_row and out_valid must stay stable until accepted.
- Pop occurs when out_valid & out_ready. Push occurs when row_push and (not full, or pop in the same cycle).
- Full with simultaneous push and pop: both happen, count unchanged. Empty with push and no pop: count becomes 1.
- Full with push and no pop: row dropped, overflow set, FIFO contents untouched.
- Row counter: increments on each pop and saturates at tile_rows. When a pop brings the count to tile_rows (tile_rows!=0), tile_done pulses for exactly one cycle, coincident with the cycle after that pop edge.
- start: clears the row counter, overflow and skew_err, and latches tile_rows.
  - FIFO contents and the delay line are not flushed, so rows in flight still drain.
  - start coincident with a pop: the counter is cleared and that pop is not counted.
- Pointers wrap modulo fifo_depth. fifo_count is held 0..fifo_depth.
- Arithmetic: no width change. Data is moved bit-exact, with sign preserved.
- Reset mid-tile: everything is discarded immediately and no tile_done is produced.

Decomposition:
- Shared package/header: data_size default, cols default, and the column-slice macro/function for packed row indexing. The same packing is used by the array input feeder.
- One natural sub-module: sync_fifo (parameters width=cols*data_size, depth=fifo_depth) with push/pop/full/empty/count.
- The de-skew delay lines are generated inline with a generate loop.

Test Plan:
- Single row, cols=4, out_ready=1: col j presents value 10+j with col_valid[j] at edge t0+j → out_valid at cycle t0+4, out_row={13,12,11,10} (col3..col0), fifo_count returns to 0.
- Streaming 6 rows back-to-back, tile_rows=6, out_ready=1 → rows emerge in order one per cycle, tile_done pulses once after the 6th pop, no flags.
- Backpressure: out_ready=0, push 9 rows into fifo_depth=8 → fifo_count=8, 9th row dropped, overflow=1; then out_ready=1 yields exactly rows 1..8 unchanged.
- Full with simultaneous push and pop: FIFO at 8, out_ready=1 while a row is pushed → fifo_count stays 8, overflow stays 0, order preserved.
- Skew error: assert col_valid[3] one cycle early relative to col_valid[0] → skew_err=1 and sticky; a later start clears it to 0.
- Signed data and reset: push a row of -1 (0xFFFF) and -32768 values, then deassert reset mid-stream → out_row bit-exact before reset; immediately after reset out_valid=0, fifo_count=0, tile_done never pulses.

Source files
------------

// File: rtl/systolic_drain_collector_pkg.sv
// Shared sizing defaults and packed-row helpers for the systolic array drain path.
// The same column packing is used by the array input feeder.
package systolic_drain_collector_pkg;

    localparam int DATA_SIZE  = 16;
    localparam int COLS       = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int CNT_WIDTH  = 8;
    localparam int ROW_WIDTH  = COLS * DATA_SIZE;

    // Extract column `col` from a packed row (column 0 in the least significant slice).
    function automatic logic [DATA_SIZE-1:0] col_slice(input logic [ROW_WIDTH-1:0] row,
                                                       input int unsigned col);
        return row[col*DATA_SIZE +: DATA_SIZE];
    endfunction

endpackage

// File: rtl/systolic_drain_collector_sync_fifo.sv
// First-word-fall-through synchronous FIFO holding aligned result rows.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nxt_s;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);
    assign dout      = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];
    assign count     = count_r;

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        count_nxt_s = count_r;
        case ({do_push_s, do_pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, occupancy and storage; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            mem_r    <= '{default: {WIDTH{1'b0}}};
        end else begin
            count_r <= count_nxt_s;
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
        end
    end

endmodule

// File: rtl/systolic_drain_collector.sv
// De-skews the bottom-edge column outputs of a systolic MAC array into aligned rows,
// buffers them, and delivers them downstream with per-tile row counting and error flags.
module systolic_drain_collector
    import systolic_drain_collector_pkg::*;
#(
    parameter int data_size  = DATA_SIZE,
    parameter int cols       = COLS,
    parameter int fifo_depth = FIFO_DEPTH,
    parameter int cnt_width  = CNT_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [cnt_width-1:0]          tile_rows,
    input  logic [cols-1:0]               col_valid,
    input  logic [cols*data_size-1:0]     col_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [cols*data_size-1:0]     out_row,
    output logic [$clog2(fifo_depth):0]   fifo_count,
    output logic                          tile_done,
    output logic                          overflow,
    output logic                          skew_err
);

    localparam int ROW_W = cols * data_size;

    logic [ROW_W-1:0]     aligned_row_s;
    logic [cols-2:0]      v0_dly_r;
    logic                 row_push_s;
    logic                 skew_mis_s;
    logic                 pop_s;
    logic                 drop_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic [cnt_width-1:0] row_cnt_r;
    logic [cnt_width-1:0] tile_rows_r;
    logic                 tile_done_r;
    logic                 overflow_r;
    logic                 skew_err_r;

    // Column 0's valid travels the longest path; its delayed copy marks a complete row.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v0_dly_r <= {(cols-1){1'b0}};
        end else begin
            v0_dly_r[0] <= col_valid[0];
            for (int i = 1; i < cols - 1; i++) begin
                v0_dly_r[i] <= v0_dly_r[i-1];
            end
        end
    end

    for (genvar j = 0; j < cols; j++) begin : g_col
        localparam int STAGES = cols - 1 - j;
        if (STAGES == 0) begin : g_direct
            assign aligned_row_s[j*data_size +: data_size] =
                col_valid[j] ? col_data[j*data_size +: data_size] : {data_size{1'b0}};
        end else begin : g_pipe
            logic [data_size-1:0] pipe_r [STAGES];

            // Delay column j so it lines up with the last column; invalid samples enter as zero.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    pipe_r <= '{default: {data_size{1'b0}}};
                end else begin
                    pipe_r[0] <= col_valid[j] ? col_data[j*data_size +: data_size]
                                              : {data_size{1'b0}};
                    for (int i = 1; i < STAGES; i++) begin
                        pipe_r[i] <= pipe_r[i-1];
                    end
                end
            end

            assign aligned_row_s[j*data_size +: data_size] = pipe_r[STAGES-1];
        end
    end

    assign row_push_s = v0_dly_r[cols-2];
    assign skew_mis_s = row_push_s ^ col_valid[cols-1];
    assign out_valid  = ~fifo_empty_s;
    assign pop_s      = out_valid & out_ready;
    assign drop_s     = row_push_s & fifo_full_s & ~pop_s;

    sync_fifo #(
        .WIDTH (ROW_W),
        .DEPTH (fifo_depth)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (row_push_s),
        .pop   (pop_s),
        .din   (aligned_row_s),
        .dout  (out_row),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count)
    );

    // Per-tile row counter; saturates at tile_rows and a start overrides a coincident pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_cnt_r   <= {cnt_width{1'b0}};
            tile_rows_r <= {cnt_width{1'b0}};
            tile_done_r <= 1'b0;
        end else if (start) begin
            row_cnt_r   <= {cnt_width{1'b0}};
            tile_rows_r <= tile_rows;
            tile_done_r <= 1'b0;
        end else if (pop_s && (row_cnt_r < tile_rows_r)) begin
            row_cnt_r   <= row_cnt_r + cnt_width'(1);
            tile_done_r <= ((row_cnt_r + cnt_width'(1)) == tile_rows_r);
        end else begin
            tile_done_r <= 1'b0;
        end
    end

    // Sticky protocol flags, cleared only by start or reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_r <= 1'b0;
            skew_err_r <= 1'b0;
        end else if (start) begin
            overflow_r <= 1'b0;
            skew_err_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r | drop_s;
            skew_err_r <= skew_err_r | skew_mis_s;
        end
    end

    assign tile_done = tile_done_r;
    assign overflow  = overflow_r;
    assign skew_err  = skew_err_r;

endmodule
